// File: rtl/clock_sequencer_if.sv
// Signal bundle between the front panel/CPU and clock_sequencer.
// The master drives the buttons and halt; the sequencer (slave) returns the CPU clock and its status.
interface clock_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             btn_run;
  logic             btn_step;
  logic             halt;
  logic             cpu_clk;
  logic             running;
  logic             halted;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output btn_run, btn_step, halt,
    input  cpu_clk, running, halted, cycle_count
  );

  modport slave (
    input  btn_run, btn_step, halt,
    output cpu_clk, running, halted, cycle_count
  );
endinterface

// File: rtl/clock_sequencer.sv
// Run/pause/single-step CPU clock generator with debounced front-panel buttons and a clean HLT freeze.
// Defining CLKSEQ_DEBOUNCE_BYPASS_EN removes the debounce counters (synchronised level goes straight to the edge detector).
module clock_sequencer #(
  parameter int DIV             = 12_000_000,
  parameter int DEBOUNCE_CYCLES = 120_000,
  parameter int CNT_W           = 16
) (
  input logic              sys_clk,
  input logic              rst,
  clock_sequencer_if.slave bus
);

  localparam int               DIV_W    = $clog2(DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {
    PAUSED,
    RUN,
    STEP,
    HALTED
  } state_t;

  // Bit 0 is the run button, bit 1 the step button.
  logic [1:0] btn_raw;
  logic [1:0] sync_ff1;
  logic [1:0] sync_ff2;
  logic [1:0] db_level;
  logic [1:0] db_level_d;
  logic [1:0] press;
  logic       run_press;
  logic       step_press;

  assign btn_raw = {bus.btn_step, bus.btn_run};

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync_ff1 <= '0;
      sync_ff2 <= '0;
    end else begin
      sync_ff1 <= btn_raw;
      sync_ff2 <= sync_ff1;
    end
  end

`ifdef CLKSEQ_DEBOUNCE_BYPASS_EN
  assign db_level = sync_ff2;
`else
  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0][DB_W-1:0] db_cnt;
  logic [1:0]           db_level_q;

  // A level that disagrees with the accepted one must hold for DEBOUNCE_CYCLES in a row;
  // any return to the accepted level restarts the count.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      db_cnt     <= '0;
      db_level_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_ff2[i] == db_level_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]     <= '0;
          db_level_q[i] <= sync_ff2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign db_level = db_level_q;
`endif

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      db_level_d <= '0;
    end else begin
      db_level_d <= db_level;
    end
  end

  assign press      = db_level & ~db_level_d;
  assign run_press  = press[0];
  assign step_press = press[1];

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic             cpu_clk_q;
  logic             running_q;
  logic             halted_q;
  logic             pause_pend;
  logic             halt_pend;
  logic [CNT_W-1:0] cycle_cnt;
  logic             terminal;
  logic             halt_req;
  logic             pause_req;

  assign terminal  = (div_cnt == DIV_LAST);
  assign halt_req  = bus.halt | halt_pend;
  assign pause_req = run_press | pause_pend;

  // Requests arriving during a high phase are parked in *_pend so the phase always runs its full DIV cycles.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state      <= PAUSED;
      div_cnt    <= '0;
      cpu_clk_q  <= 1'b0;
      running_q  <= 1'b0;
      halted_q   <= 1'b0;
      pause_pend <= 1'b0;
      halt_pend  <= 1'b0;
      cycle_cnt  <= '0;
    end else begin
      case (state)
        PAUSED: begin
          cpu_clk_q  <= 1'b0;
          div_cnt    <= '0;
          pause_pend <= 1'b0;
          halt_pend  <= 1'b0;
          if (bus.halt) begin
            state    <= HALTED;
            halted_q <= 1'b1;
          end else if (run_press) begin
            state     <= RUN;
            running_q <= 1'b1;
          end else if (step_press) begin
            state     <= STEP;
            cpu_clk_q <= 1'b1;
            cycle_cnt <= cycle_cnt + 1'b1;
          end
        end

        RUN: begin
          if (!cpu_clk_q) begin
            if (halt_req) begin
              state      <= HALTED;
              running_q  <= 1'b0;
              halted_q   <= 1'b1;
              div_cnt    <= '0;
              pause_pend <= 1'b0;
              halt_pend  <= 1'b0;
            end else if (pause_req) begin
              state      <= PAUSED;
              running_q  <= 1'b0;
              div_cnt    <= '0;
              pause_pend <= 1'b0;
            end else if (terminal) begin
              cpu_clk_q <= 1'b1;
              div_cnt   <= '0;
              cycle_cnt <= cycle_cnt + 1'b1;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end else if (terminal) begin
            cpu_clk_q  <= 1'b0;
            div_cnt    <= '0;
            pause_pend <= 1'b0;
            halt_pend  <= 1'b0;
            if (halt_req) begin
              state     <= HALTED;
              running_q <= 1'b0;
              halted_q  <= 1'b1;
            end else if (pause_req) begin
              state     <= PAUSED;
              running_q <= 1'b0;
            end
          end else begin
            div_cnt    <= div_cnt + 1'b1;
            pause_pend <= pause_pend | run_press;
            halt_pend  <= halt_pend | bus.halt;
          end
        end

        STEP: begin
          if (terminal) begin
            cpu_clk_q <= 1'b0;
            div_cnt   <= '0;
            halt_pend <= 1'b0;
            if (halt_req) begin
              state    <= HALTED;
              halted_q <= 1'b1;
            end else begin
              state <= PAUSED;
            end
          end else begin
            div_cnt   <= div_cnt + 1'b1;
            halt_pend <= halt_pend | bus.halt;
          end
        end

        HALTED: begin
          cpu_clk_q <= 1'b0;
          running_q <= 1'b0;
          halted_q  <= 1'b1;
        end

        default: begin
          state     <= PAUSED;
          cpu_clk_q <= 1'b0;
          running_q <= 1'b0;
          halted_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_clk     = cpu_clk_q;
  assign bus.running     = running_q;
  assign bus.halted      = halted_q;
  assign bus.cycle_count = cycle_cnt;

endmodule

// File: tb/tb_clock_sequencer.sv
// Directed self-checking bench for clock_sequencer with DIV=4, DEBOUNCE_CYCLES=8, CNT_W=4.
// Inputs change and outputs are sampled 2 time units after each sys_clk rising edge.
module tb_clock_sequencer;

  localparam int DIV             = 4;
  localparam int DEBOUNCE_CYCLES = 8;
  localparam int CNT_W           = 4;
`ifdef CLKSEQ_DEBOUNCE_BYPASS_EN
  localparam int LAT          = 3;
  localparam int BOUNCE_STEPS = 6;
`else
  localparam int LAT          = 2 + DEBOUNCE_CYCLES + 1;
  localparam int BOUNCE_STEPS = 1;
`endif

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;

  clock_sequencer_if #(.CNT_W(CNT_W)) bus ();

  clock_sequencer #(
    .DIV            (DIV),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int   checks = 0;
  int   errors = 0;
  int   exp_cc = 0;
  int   rises_before = 0;

  // Phase-length monitor: counts sys_clk cycles spent in each cpu_clk level.
  logic prev_clk = 1'b0;
  int   hi_len = 0;
  int   lo_len = 0;
  int   last_hi = 0;
  int   last_lo = 0;
  int   rises = 0;

  always @(negedge sys_clk) begin
    if (rst) begin
      prev_clk <= 1'b0;
      hi_len   <= 0;
      lo_len   <= 0;
      last_hi  <= 0;
      last_lo  <= 0;
      rises    <= 0;
    end else begin
      if (bus.cpu_clk) begin
        if (!prev_clk) begin
          rises   <= rises + 1;
          last_lo <= lo_len;
          lo_len  <= 0;
          hi_len  <= 1;
        end else begin
          hi_len <= hi_len + 1;
        end
      end else begin
        if (prev_clk) begin
          last_hi <= hi_len;
          hi_len  <= 0;
          lo_len  <= 1;
        end else begin
          lo_len <= lo_len + 1;
        end
      end
      prev_clk <= bus.cpu_clk;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic run, input logic step, input logic hlt, input int n);
    bus.btn_run  = run;
    bus.btn_step = step;
    bus.halt     = hlt;
    tick(n);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkStatus(input string tag, input logic cpu, input logic run, input logic hlt);
    checkOutput({tag, ".cpu_clk"}, 32'(bus.cpu_clk), 32'(cpu));
    checkOutput({tag, ".running"}, 32'(bus.running), 32'(run));
    checkOutput({tag, ".halted"},  32'(bus.halted),  32'(hlt));
  endtask

  initial begin
    bus.btn_run  = 1'b0;
    bus.btn_step = 1'b0;
    bus.halt     = 1'b0;

    // Reset held for three cycles while the buttons toggle.
    for (int i = 0; i < 3; i++) applyStimulus(i[0] == 1'b0, i[0] == 1'b1, 1'b0, 1);
    checkStatus("reset", 1'b0, 1'b0, 1'b0);
    checkOutput("reset.cycle_count", 32'(bus.cycle_count), 0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 20);
    checkStatus("idle", 1'b0, 1'b0, 1'b0);

    // Run: entry after the press latency, first rise DIV cycles later, wrap after 16 rises, pause mid-high.
    $display("[TB] run / wrap / pause");
    bus.btn_run = 1'b1;
    tick(LAT - 1);
    checkOutput("run_latency.running", 32'(bus.running), 0);
    tick(1);
    checkStatus("run_entry", 1'b0, 1'b1, 1'b0);
    tick(3);
    checkOutput("run_first_low.cpu_clk", 32'(bus.cpu_clk), 0);
    tick(1);
    checkOutput("run_first_rise.cpu_clk", 32'(bus.cpu_clk), 1);
    checkOutput("run_first_rise.cycle_count", 32'(bus.cycle_count), 1);
    tick(5);
    bus.btn_run = 1'b0;
    checkOutput("run_low.cpu_clk", 32'(bus.cpu_clk), 0);
    for (int k = 10; k <= 130; k++) begin
      tick(1);
      if (k == 127 - LAT) bus.btn_run = 1'b1;
      if (k == 130) bus.btn_run = 1'b0;
      if (k == 123) begin
        checkOutput("pre_wrap.cycle_count", 32'(bus.cycle_count), 15);
        checkOutput("pre_wrap.cpu_clk", 32'(bus.cpu_clk), 0);
        checkOutput("run_high_len", 32'(last_hi), DIV);
        checkOutput("run_low_len", 32'(last_lo), DIV);
      end
      if (k == 124) begin
        checkOutput("wrap.cycle_count", 32'(bus.cycle_count), 0);
        checkOutput("wrap.cpu_clk", 32'(bus.cpu_clk), 1);
      end
      if (k == 127) checkStatus("pause_pending", 1'b1, 1'b1, 1'b0);
      if (k == 128) checkStatus("paused", 1'b0, 1'b0, 1'b0);
      if (k == 129) checkOutput("pause_high_len", 32'(last_hi), DIV);
    end
    tick(20);

    // Single step, with a run press landing inside the pulse that must be ignored.
    $display("[TB] single step");
    bus.btn_step = 1'b1;
    tick(1);
    bus.btn_run = 1'b1;
    tick(LAT - 2);
    checkOutput("step_wait.cpu_clk", 32'(bus.cpu_clk), 0);
    tick(1);
    checkStatus("step_rise", 1'b1, 1'b0, 1'b0);
    checkOutput("step_rise.cycle_count", 32'(bus.cycle_count), 1);
    tick(1);
    checkOutput("step_run_ignored.running", 32'(bus.running), 0);
    tick(2);
    checkOutput("step_last_high.cpu_clk", 32'(bus.cpu_clk), 1);
    tick(1);
    checkStatus("step_done", 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("step_high_len", 32'(last_hi), DIV);
    applyStimulus(1'b0, 1'b0, 1'b0, 20);
    checkStatus("step_idle", 1'b0, 1'b0, 1'b0);
    exp_cc = 1;
    checkOutput("step_idle.cycle_count", 32'(bus.cycle_count), exp_cc);

    // Chattering step button followed by a clean hold.
    $display("[TB] bounce");
    rises_before = rises;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 3);
      applyStimulus(1'b0, 1'b0, 1'b0, 3);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 30);
    exp_cc = exp_cc + BOUNCE_STEPS;
    checkOutput("bounce.cycle_count", 32'(bus.cycle_count), exp_cc);
    checkOutput("bounce.pulses", 32'(rises - rises_before), BOUNCE_STEPS);
    checkOutput("bounce.high_len", 32'(last_hi), DIV);
    checkStatus("bounce_end", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 20);

    // Halt raised one cycle into a high phase: the phase completes, then HALTED.
    $display("[TB] halt");
    bus.btn_run = 1'b1;
    tick(LAT);
    checkOutput("halt_run_entry.running", 32'(bus.running), 1);
    bus.btn_run = 1'b0;
    tick(4);
    exp_cc = exp_cc + 1;
    checkOutput("halt_rise.cpu_clk", 32'(bus.cpu_clk), 1);
    checkOutput("halt_rise.cycle_count", 32'(bus.cycle_count), exp_cc);
    tick(1);
    bus.halt = 1'b1;
    tick(1);
    bus.halt = 1'b0;
    checkStatus("halt_high_a", 1'b1, 1'b1, 1'b0);
    tick(1);
    checkStatus("halt_high_b", 1'b1, 1'b1, 1'b0);
    tick(1);
    checkStatus("halted", 1'b0, 1'b0, 1'b1);
    tick(1);
    checkOutput("halt_high_len", 32'(last_hi), DIV);

    rises_before = rises;
    applyStimulus(1'b1, 1'b1, 1'b0, 20);
    applyStimulus(1'b0, 1'b0, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 20);
    checkStatus("halted_hold", 1'b0, 1'b0, 1'b1);
    checkOutput("halted_hold.cycle_count", 32'(bus.cycle_count), exp_cc);
    checkOutput("halted_hold.rises", 32'(rises - rises_before), 0);

    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkStatus("reset_from_halt", 1'b0, 1'b0, 1'b0);
    checkOutput("reset_from_halt.cycle_count", 32'(bus.cycle_count), 0);

    // Halt while paused takes effect on the next edge.
    tick(2);
    bus.halt = 1'b1;
    tick(1);
    bus.halt = 1'b0;
    checkStatus("halt_from_paused", 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    checkStatus("final_reset", 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
